// File: rtl/serial_divider_if.sv
// Start/ready handshake bundle shared by the serial divider and its requester.
interface serial_divider_if;
  logic        start;
  logic [15:0] Dividend;
  logic [7:0]  Divisor;
  logic [7:0]  Quotient;
  logic [7:0]  Remainder;
  logic        ready;
  logic        dbz;
  logic        ovf;

  modport master (
    output start, Dividend, Divisor,
    input  Quotient, Remainder, ready, dbz, ovf
  );

  modport slave (
    input  start, Dividend, Divisor,
    output Quotient, Remainder, ready, dbz, ovf
  );
endinterface

// File: rtl/serial_divider.sv
// Restoring divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder, one bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (adds one sign-fix cycle after the iterations).
module serial_divider (
  input logic             clk,
  input logic             rst,
  serial_divider_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    EARLY,
    RUN,
    DONE
`ifdef SIGNED_DIV_EN
    , FIX
`endif
  } state_t;

  state_t     state;
  logic [2:0] cnt;

  // Working registers: partial remainder, quotient/dividend shift register, divisor
  logic [7:0] rem_w;
  logic [7:0] quo_w;
  logic [7:0] div_w;
  logic [7:0] exit_rem;
  logic       exit_dbz;

  logic [15:0] dvd_mag;
  logic [7:0]  dsr_mag;
  logic        ovf_chk;

`ifdef SIGNED_DIV_EN
  logic signed [15:0] dvd_s;
  logic signed [7:0]  dsr_s;
  logic               neg_q;
  logic               neg_r;

  function automatic logic [7:0] apply_sign(input logic [7:0] mag, input logic neg);
    logic signed [7:0] m;
    m = $signed(mag);
    return neg ? $unsigned(-m) : mag;
  endfunction

  // A magnitude quotient of 128 or more cannot be represented; -128 is rejected too
  always_comb begin
    dvd_s   = $signed(bus.Dividend);
    dsr_s   = $signed(bus.Divisor);
    dvd_mag = $unsigned((dvd_s < 0) ? -dvd_s : dvd_s);
    dsr_mag = $unsigned((dsr_s < 0) ? -dsr_s : dsr_s);
    ovf_chk = dvd_mag[15:7] >= {1'b0, dsr_mag};
  end
`else
  always_comb begin
    dvd_mag = bus.Dividend;
    dsr_mag = bus.Divisor;
    ovf_chk = bus.Dividend[15:8] >= bus.Divisor;
  end
`endif

  // One restoring step; the 8-bit difference is exact whenever the trial subtraction succeeds
  logic [8:0] rem_sh;
  logic       ge;
  logic [7:0] diff;
  logic [7:0] rem_nx;
  logic [7:0] quo_nx;

  always_comb begin
    rem_sh = {rem_w, quo_w[7]};
    ge     = rem_sh >= {1'b0, div_w};
    diff   = rem_sh[7:0] - div_w;
    rem_nx = ge ? diff : rem_sh[7:0];
    quo_nx = {quo_w[6:0], ge};
  end

  // Datapath: loaded on start, shifted while running, never reset
  always_ff @(posedge clk) begin
    if (bus.start) begin
      rem_w    <= dvd_mag[15:8];
      quo_w    <= dvd_mag[7:0];
      div_w    <= dsr_mag;
      exit_dbz <= (bus.Divisor == 8'h00);
      exit_rem <= (bus.Divisor == 8'h00) ? bus.Dividend[7:0] : 8'h00;
`ifdef SIGNED_DIV_EN
      neg_q    <= bus.Dividend[15] ^ bus.Divisor[7];
      neg_r    <= bus.Dividend[15];
`endif
    end else if (state == RUN) begin
      rem_w <= rem_nx;
      quo_w <= quo_nx;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      bus.Quotient  <= 8'h00;
      bus.Remainder <= 8'h00;
      bus.ready     <= 1'b1;
      bus.dbz       <= 1'b0;
      bus.ovf       <= 1'b0;
    end else if (bus.start) begin
      state     <= ((bus.Divisor == 8'h00) || ovf_chk) ? EARLY : RUN;
      cnt       <= 3'd0;
      bus.ready <= 1'b0;
      bus.dbz   <= 1'b0;
      bus.ovf   <= 1'b0;
    end else begin
      case (state)
        EARLY: begin
          bus.Quotient  <= 8'hFF;
          bus.Remainder <= exit_rem;
          bus.dbz       <= exit_dbz;
          bus.ovf       <= !exit_dbz;
          bus.ready     <= 1'b1;
          state         <= DONE;
        end
        RUN: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
`ifdef SIGNED_DIV_EN
            state <= FIX;
`else
            bus.Quotient  <= quo_nx;
            bus.Remainder <= rem_nx;
            bus.ready     <= 1'b1;
            state         <= DONE;
`endif
          end
        end
`ifdef SIGNED_DIV_EN
        FIX: begin
          bus.Quotient  <= apply_sign(quo_w, neg_q);
          bus.Remainder <= apply_sign(rem_w, neg_r);
          bus.ready     <= 1'b1;
          state         <= DONE;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: vector table, hand sequences, randomized ops vs. arithmetic model.
module tb_serial_divider;

  logic clk = 1'b0;
  logic rst;

  serial_divider_if bus();

  serial_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef SIGNED_DIV_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division from the arithmetic definition
  task automatic ref_div(input logic [15:0] dd, input logic [7:0] dv,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic z, output logic o, output int lat);
    int a, b, qi, ri;
`ifdef SIGNED_DIV_EN
    a = $signed(dd);
    b = $signed(dv);
`else
    a = int'(dd);
    b = int'(dv);
`endif
    z = 1'b0; o = 1'b0; q = 8'hFF; r = 8'h00; lat = 1;
    if (b == 0) begin
      z = 1'b1;
      r = dd[7:0];
    end else begin
      qi = a / b;
      ri = a % b;
`ifdef SIGNED_DIV_EN
      if (qi > 127 || qi < -127) o = 1'b1;
`else
      if (qi > 255) o = 1'b1;
`endif
      else begin
        q   = qi[7:0];
        r   = ri[7:0];
        lat = LAT;
      end
    end
  endtask

  task automatic run_check(input logic [15:0] dd, input logic [7:0] dv,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic ez, input logic eo, input int elat, input string nm);
    int n;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.Dividend = dd;
    bus.Divisor  = dv;
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, ".busy"},     {31'd0, bus.ready}, 32'd0);
    chk({nm, ".dbz_clr"},  {31'd0, bus.dbz},   32'd0);
    chk({nm, ".ovf_clr"},  {31'd0, bus.ovf},   32'd0);
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".latency"}, n, elat);
    chk({nm, ".q"},   {24'd0, bus.Quotient},  {24'd0, eq});
    chk({nm, ".r"},   {24'd0, bus.Remainder}, {24'd0, er});
    chk({nm, ".dbz"}, {31'd0, bus.dbz}, {31'd0, ez});
    chk({nm, ".ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
  endtask

  task automatic model_op(input logic [15:0] dd, input logic [7:0] dv, input string nm);
    logic [7:0] q, r;
    logic z, o;
    int lat;
    ref_div(dd, dv, q, r, z, o, lat);
    run_check(dd, dv, q, r, z, o, lat, nm);
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    logic ok;
    logic [15:0] dd;
    logic [7:0]  dv;
    int sel, sh;

`ifdef SIGNED_DIV_EN
    vecs[0] = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 9};
    vecs[1] = '{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 9};
    vecs[2] = '{16'h8000, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
    vecs[3] = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1};
    vecs[4] = '{16'h3F80, 8'h80, 8'h81, 8'h00, 1'b0, 1'b0, 9};
    vecs[5] = '{16'h4000, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
    vecs[6] = '{16'hFFFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
    vecs[7] = '{16'hFFF9, 8'hF9, 8'h01, 8'h00, 1'b0, 1'b0, 9};
    vecs[8] = '{16'h8000, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1};
    vecs[9] = '{16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, 9};
`else
    vecs[0] = '{16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 8};
    vecs[1] = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1};
    vecs[2] = '{16'h0800, 8'h08, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
    vecs[3] = '{16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, 8};
    vecs[4] = '{16'h07FF, 8'h08, 8'hFF, 8'h07, 1'b0, 1'b0, 8};
    vecs[5] = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
    vecs[6] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 8};
    vecs[7] = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 8};
    vecs[8] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 8};
    vecs[9] = '{16'h0005, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0, 1};
`endif

    // Reset held with start asserted
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.Dividend = 16'h03E8;
    bus.Divisor  = 8'h07;
    repeat (2) @(negedge clk);
    chk("reset.ready", {31'd0, bus.ready}, 32'd1);
    chk("reset.q",     {24'd0, bus.Quotient},  32'd0);
    chk("reset.r",     {24'd0, bus.Remainder}, 32'd0);
    chk("reset.dbz",   {31'd0, bus.dbz}, 32'd0);
    chk("reset.ovf",   {31'd0, bus.ovf}, 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;

    for (int i = 0; i < 10; i++)
      run_check(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].o,
                vecs[i].lat, $sformatf("vec%0d", i));

    // Restart at cycle 4 aborts the first op without a ready pulse
    @(negedge clk);
    bus.start = 1'b1;
`ifdef SIGNED_DIV_EN
    bus.Dividend = 16'h0190;
`else
    bus.Dividend = 16'h03E8;
`endif
    bus.Divisor = 8'h07;
    @(negedge clk);
    bus.start = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.ready !== 1'b0) ok = 1'b0;
    end
    bus.start    = 1'b1;
    bus.Dividend = 16'h0064;
    bus.Divisor  = 8'h0A;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.ready !== 1'b0) ok = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("restart.no_ready", {31'd0, ok}, 32'd1);
    chk("restart.latency", n, LAT);
    chk("restart.q", {24'd0, bus.Quotient},  32'h0A);
    chk("restart.r", {24'd0, bus.Remainder}, 32'h00);

    // start held high keeps re-triggering
    @(negedge clk);
    bus.start    = 1'b1;
    bus.Dividend = 16'h0190;
    bus.Divisor  = 8'h07;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.ready !== 1'b0) ok = 1'b0;
    end
    bus.start = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold.no_ready", {31'd0, ok}, 32'd1);
    chk("hold.latency", n, LAT);
    chk("hold.q", {24'd0, bus.Quotient},  32'h39);
    chk("hold.r", {24'd0, bus.Remainder}, 32'h01);

    // Reset in the middle of RUN discards everything
    @(negedge clk);
    bus.start    = 1'b1;
    bus.Dividend = 16'h0190;
    bus.Divisor  = 8'h05;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.ready", {31'd0, bus.ready}, 32'd1);
    chk("midrst.q",     {24'd0, bus.Quotient},  32'd0);
    chk("midrst.r",     {24'd0, bus.Remainder}, 32'd0);
    repeat (10) @(negedge clk);
    chk("midrst.hold_ready", {31'd0, bus.ready}, 32'd1);
    chk("midrst.hold_q",     {24'd0, bus.Quotient}, 32'd0);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 7);
      dd  = 16'($urandom);
      dv  = 8'($urandom_range(0, 255));
      if (sel == 0) dv = 8'h00;
      else if (sel >= 3) begin
        if (dv == 8'h00) dv = 8'h01;
        sh = $urandom_range(0, 15);
`ifdef SIGNED_DIV_EN
        dd = 16'($signed(dd) >>> sh);
`else
        dd = dd >> sh;
`endif
      end
      model_op(dd, dv, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
